board_date_sequencer: RTL and testbench



---
 rtl/board_date_sequencer_if.sv | 13 +
 rtl/board_date_sequencer.sv | 143 ++++++++++++++
 tb/tb_board_date_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/board_date_sequencer_if.sv
// Board-pin bundle between the top level and the front-panel sequencer.
interface board_date_sequencer_if #(
  parameter int unsigned SW_WIDTH   = 8,
  parameter int unsigned NUM_DIGITS = 6
);
  logic [SW_WIDTH-1:0]     switch;
  logic [1:0]              key;
  logic [SW_WIDTH+1:0]     leds;
  logic [8*NUM_DIGITS-1:0] hex;

  modport master (output switch, key, input leds, hex);
  modport slave  (input switch, key, output leds, hex);
endinterface

// File: rtl/board_date_sequencer.sv
// Front-panel controller: switch mirror with latched invert, date table on the
// seven-segment digits stepped by short presses or auto-scroll (long press).
module board_date_sequencer #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned NUM_DIGITS      = 6,
  parameter int unsigned NUM_DATES       = 2,
  parameter logic [NUM_DATES*NUM_DIGITS*4-1:0] DATES = 48'h082401_082301,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned AUTO_CYCLES     = 100000000
) (
  input logic clk,
  input logic rst_n,
  board_date_sequencer_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_DATES > 2) ? $clog2(NUM_DATES) : 1;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned AUTO_W = $clog2(AUTO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [1:0]          key_s1_q, key_s2_q, key_db_q, press_q, armed_q, start_q;
  logic                release_q;
  logic [DB_W-1:0]     db_cnt_q [2];
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [AUTO_W-1:0]   timer_q;
  logic [IDX_W-1:0]    idx_q;
  logic                inv_q, auto_q;

  logic [SW_WIDTH+1:0]     leds_q;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    manual_adv, auto_tc, auto_toggle;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'hFF;
    endcase
  endfunction

  // A key is armed only once its synchronised level has been seen released after
  // reset, so a button held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= '1;
      key_s2_q  <= '1;
      key_db_q  <= '1;
      press_q   <= '0;
      release_q <= 1'b0;
      armed_q   <= '0;
      start_q   <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      for (int unsigned k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      key_s1_q  <= bus.key;
      key_s2_q  <= key_s1_q;
      sw_s1_q   <= bus.switch;
      sw_s2_q   <= sw_s1_q;
      press_q   <= '0;
      release_q <= 1'b0;
      if (start_q != 2'd2) start_q <= start_q + 2'd1;
      for (int unsigned k = 0; k < 2; k++) begin
        if (start_q == 2'd2 && key_s2_q[k]) armed_q[k] <= 1'b1;
        if (key_s2_q[k] == key_db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q[k] <= '0;
          key_db_q[k] <= key_s2_q[k];
          press_q[k]  <= ~key_s2_q[k] & armed_q[k];
          if (k == 1) release_q <= key_s2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    manual_adv  = (state_q == PRESSED) && release_q;
    auto_toggle = (state_q == PRESSED) && !release_q && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    auto_tc     = auto_q && (timer_q == AUTO_W'(AUTO_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      if (press_q[0]) inv_q <= ~inv_q;
      case (state_q)
        IDLE: if (press_q[1]) begin
          state_q <= PRESSED;
          hold_q  <= '0;
        end
        PRESSED: begin
          if (release_q)        state_q <= IDLE;
          else if (auto_toggle) state_q <= HELD;
          else                  hold_q  <= hold_q + HOLD_W'(1);
        end
        HELD:    if (release_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (auto_toggle) auto_q <= ~auto_q;
      // A manual advance landing on the terminal count merges into one step.
      if (auto_toggle || !auto_q || manual_adv || auto_tc) timer_q <= '0;
      else timer_q <= timer_q + AUTO_W'(1);
      if (manual_adv || auto_tc)
        idx_q <= (idx_q == IDX_W'(NUM_DATES - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      hex_d[d*8 +: 8] = seg7(DATES[(int'(idx_q) * NUM_DIGITS + d) * 4 +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
      hex_q  <= '1;
    end else begin
      leds_q <= {auto_q, inv_q, sw_s2_q ^ {SW_WIDTH{inv_q}}};
      hex_q  <= hex_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.hex  = hex_q;

endmodule

// File: tb/tb_board_date_sequencer.sv
// Directed bench for board_date_sequencer: reset, switch mirror, invert, short/long
// presses, auto-scroll timing, manual/auto coincidence and reset mid-activity.
module tb_board_date_sequencer;
  localparam int unsigned SW = 8;
  localparam int unsigned ND = 6;
  localparam logic [47:0] D0    = 48'hC080A4B0C0F9;
  localparam logic [47:0] D1    = 48'hC080A499C0F9;
  localparam logic [47:0] BLANK = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  board_date_sequencer_if #(.SW_WIDTH(SW), .NUM_DIGITS(ND)) bus ();

  board_date_sequencer #(
    .SW_WIDTH(SW), .NUM_DIGITS(ND), .NUM_DATES(2), .DATES(48'h082401_082301),
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .AUTO_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.switch = 8'hA5; bus.key = 2'b11;
    step(3);
    checks++; if (bus.hex !== BLANK) begin errors++; $display("FAIL reset_hex: got %h expected %h", bus.hex, BLANK); end
    checks++; if (bus.leds !== 10'h000) begin errors++; $display("FAIL reset_leds: got %h expected %h", bus.leds, 10'h000); end
    rst_n = 1'b1;
    step(1);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL first_edge_hex: got %h expected %h", bus.hex, D0); end
    step(1);
    checks++; if (bus.leds !== 10'h000) begin errors++; $display("FAIL leds_edge2: got %h expected %h", bus.leds, 10'h000); end
    step(1);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL leds_edge3: got %h expected %h", bus.leds, 10'h0A5); end
    checks++; if (bus.hex[23:16] !== 8'hB0) begin errors++; $display("FAIL digit2_date0: got %h expected %h", bus.hex[23:16], 8'hB0); end
  endtask

  task automatic test_switch;
    bus.switch = 8'h3C;
    step(2);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL switch_edge2: got %h expected %h", bus.leds, 10'h0A5); end
    step(1);
    checks++; if (bus.leds !== 10'h03C) begin errors++; $display("FAIL switch_edge3: got %h expected %h", bus.leds, 10'h03C); end
    bus.switch = 8'hA5;
    step(3);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL switch_restore: got %h expected %h", bus.leds, 10'h0A5); end
  endtask

  task automatic test_invert;
    bus.key = 2'b10;
    step(7);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL invert_edge7: got %h expected %h", bus.leds, 10'h0A5); end
    step(1);
    checks++; if (bus.leds !== 10'h15A) begin errors++; $display("FAIL invert_edge8: got %h expected %h", bus.leds, 10'h15A); end
    step(2); bus.key = 2'b11;
    step(10);
    checks++; if (bus.leds !== 10'h15A) begin errors++; $display("FAIL invert_latched: got %h expected %h", bus.leds, 10'h15A); end
    bus.key = 2'b10;
    step(8);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL invert_second: got %h expected %h", bus.leds, 10'h0A5); end
    step(2); bus.key = 2'b11;
    step(10);
    bus.key = 2'b10; step(3); bus.key = 2'b11;
    step(12);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL glitch_ignored: got %h expected %h", bus.leds, 10'h0A5); end
  endtask

  task automatic test_short_press;
    bus.key = 2'b01;
    step(8);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL short_no_adv_on_press: got %h expected %h", bus.hex, D0); end
    bus.key = 2'b11;
    step(10);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL short_adv: got %h expected %h", bus.hex, D1); end
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL short_flags: got %h expected %h", bus.leds, 10'h0A5); end
    bus.key = 2'b01; step(8); bus.key = 2'b11;
    step(10);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL short_wrap: got %h expected %h", bus.hex, D0); end
  endtask

  task automatic test_long_press;
    bus.key = 2'b01;
    step(27);
    checks++; if (bus.leds[9] !== 1'b0) begin errors++; $display("FAIL long_auto_t27: got %b expected %b", bus.leds[9], 1'b0); end
    step(1);
    checks++; if (bus.leds[9] !== 1'b1) begin errors++; $display("FAIL long_auto_t28: got %b expected %b", bus.leds[9], 1'b1); end
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL long_no_adv: got %h expected %h", bus.hex, D0); end
    step(2); bus.key = 2'b11;
    step(7);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL auto_t37: got %h expected %h", bus.hex, D0); end
    step(1);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL auto_t38: got %h expected %h", bus.hex, D1); end
    step(9);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL auto_t47: got %h expected %h", bus.hex, D1); end
    step(1);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL auto_wrap_t48: got %h expected %h", bus.hex, D0); end
  endtask

  task automatic test_coincide;
    step(4); bus.key = 2'b01;
    step(8); bus.key = 2'b11;
    step(7);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL coincide_t67: got %h expected %h", bus.hex, D1); end
    step(1);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL coincide_single_adv: got %h expected %h", bus.hex, D0); end
    bus.key = 2'b01;
    step(7); bus.key = 2'b11;
    step(3);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL coincide_next_auto: got %h expected %h", bus.hex, D1); end
    step(5);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL manual_mid_period: got %h expected %h", bus.hex, D0); end
    step(5);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL timer_cleared_t88: got %h expected %h", bus.hex, D0); end
    step(5);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL auto_after_clear: got %h expected %h", bus.hex, D1); end
  endtask

  task automatic test_auto_stop;
    step(3); bus.key = 2'b01;
    step(27);
    checks++; if (bus.leds[9] !== 1'b1) begin errors++; $display("FAIL stop_t123: got %b expected %b", bus.leds[9], 1'b1); end
    step(1);
    checks++; if (bus.leds[9] !== 1'b0) begin errors++; $display("FAIL stop_t124: got %b expected %b", bus.leds[9], 1'b0); end
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL stop_hex: got %h expected %h", bus.hex, D0); end
    step(2); bus.key = 2'b11;
    step(25);
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL stop_static: got %h expected %h", bus.hex, D0); end
  endtask

  task automatic test_reset_mid;
    bus.key = 2'b01; step(30); bus.key = 2'b11;
    step(15);
    checks++; if (bus.leds !== 10'h2A5) begin errors++; $display("FAIL mid_scroll_leds: got %h expected %h", bus.leds, 10'h2A5); end
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL mid_scroll_hex: got %h expected %h", bus.hex, D1); end
    bus.key = 2'b01;
    step(10);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.leds !== 10'h000) begin errors++; $display("FAIL async_reset_leds: got %h expected %h", bus.leds, 10'h000); end
    checks++; if (bus.hex !== BLANK) begin errors++; $display("FAIL async_reset_hex: got %h expected %h", bus.hex, BLANK); end
    step(2); rst_n = 1'b1;
    step(3);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL post_reset_leds: got %h expected %h", bus.leds, 10'h0A5); end
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL post_reset_hex: got %h expected %h", bus.hex, D0); end
    step(30);
    checks++; if (bus.leds !== 10'h0A5) begin errors++; $display("FAIL held_key_ignored: got %h expected %h", bus.leds, 10'h0A5); end
    checks++; if (bus.hex !== D0) begin errors++; $display("FAIL held_key_no_adv: got %h expected %h", bus.hex, D0); end
    bus.key = 2'b11; step(10);
    bus.key = 2'b01; step(8); bus.key = 2'b11;
    step(10);
    checks++; if (bus.hex !== D1) begin errors++; $display("FAIL repress_acts: got %h expected %h", bus.hex, D1); end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_invert();
    test_short_press();
    test_long_press();
    test_coincide();
    test_auto_stop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
